// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: size codes, FSM states and
// the access-size legality rule.
package dmem_pkg;

  localparam logic [2:0] SZ_B  = 3'b001;
  localparam logic [2:0] SZ_H  = 3'b010;
  localparam logic [2:0] SZ_W  = 3'b011;
  localparam logic [2:0] SZ_BU = 3'b101;
  localparam logic [2:0] SZ_HU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Unsigned sizes only make sense for loads; stores take signed/word codes.
  function automatic logic size_legal(input logic we, input logic [2:0] size);
    logic ok;
    ok = 1'b0;
    case (size)
      SZ_B, SZ_H, SZ_W: ok = 1'b1;
      SZ_BU, SZ_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick. The pointer flips to favour the requester that
// was not picked whenever the owner signals an accepted request.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_update,
  output logic o_pick_b
);

  logic r_prio_b;

  assign o_pick_b = i_req_b & (~i_req_a | r_prio_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio_b <= 1'b0;
    end else if (i_update) begin
      r_prio_b <= ~o_pick_b;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory: accepts one
// request, issues one registered strobe, then returns a completion pulse.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  input  logic [2:0]        a_size,
  output logic              a_gnt,
  output logic              a_done,
  output logic [31:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  input  logic [2:0]        b_size,
  output logic              b_gnt,
  output logic              b_done,
  output logic [31:0]       b_rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_size,
  input  logic [31:0]       mem_read_data
);

  state_t            r_state;
  logic              r_sel_b;
  logic              r_we;
  logic              r_ill;
  logic              r_rd_ok;
  logic              r_gnt_a;
  logic              r_gnt_b;
  logic              r_done_a;
  logic              r_done_b;
  logic              r_err;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [2:0]        r_mem_size;

  logic              w_any_req;
  logic              w_accept;
  logic              w_pick_b;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic [2:0]        w_size;
  logic              w_legal;

  assign w_any_req = a_req | b_req;
  assign w_accept  = (r_state == ST_IDLE) & w_any_req;

  rr_arb2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .i_req_a  (a_req),
    .i_req_b  (b_req),
    .i_update (w_accept),
    .o_pick_b (w_pick_b)
  );

  assign w_we    = w_pick_b ? b_we    : a_we;
  assign w_addr  = w_pick_b ? b_addr  : a_addr;
  assign w_wdata = w_pick_b ? b_wdata : a_wdata;
  assign w_size  = w_pick_b ? b_size  : a_size;
  assign w_legal = size_legal(w_we, w_size) & (w_addr < ADDR_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sel_b     <= 1'b0;
      r_we        <= 1'b0;
      r_ill       <= 1'b0;
      r_rd_ok     <= 1'b0;
      r_gnt_a     <= 1'b0;
      r_gnt_b     <= 1'b0;
      r_done_a    <= 1'b0;
      r_done_b    <= 1'b0;
      r_err       <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_size  <= 3'b000;
    end else begin
      // Pulses default low; each state raises only what it owns.
      r_gnt_a     <= 1'b0;
      r_gnt_b     <= 1'b0;
      r_done_a    <= 1'b0;
      r_done_b    <= 1'b0;
      r_err       <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state <= ST_ISSUE;
            r_sel_b <= w_pick_b;
            r_we    <= w_we;
            r_ill   <= ~w_legal;
            r_gnt_a <= ~w_pick_b;
            r_gnt_b <= w_pick_b;
            // Memory-side fields only move for legal accesses so they hold otherwise.
            if (w_legal) begin
              r_mem_read  <= ~w_we;
              r_mem_write <= w_we;
              r_mem_addr  <= w_addr;
              r_mem_wdata <= w_wdata;
              r_mem_size  <= w_size;
            end
          end
        end
        ST_ISSUE: begin
          r_state  <= ST_RESP;
          r_done_a <= ~r_sel_b;
          r_done_b <= r_sel_b;
          r_err    <= r_ill;
          r_rd_ok  <= ~r_ill & ~r_we;
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_gnt          = r_gnt_a;
  assign b_gnt          = r_gnt_b;
  assign a_done         = r_done_a;
  assign b_done         = r_done_b;
  assign err            = r_err;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;
  assign mem_size       = r_mem_size;

  // The memory registers its output, so read data is live during the RESP cycle.
  assign a_rdata = (r_done_a & r_rd_ok) ? mem_read_data : 32'd0;
  assign b_rdata = (r_done_b & r_rd_ok) ? mem_read_data : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the arbiter and memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [2:0]  a_size, b_size;
  logic        a_gnt, a_done, b_gnt, b_done, err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_read, mem_write;
  logic [2:0]  mem_size;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(64), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_size(a_size),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_size(b_size),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .err(err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_read_data(mem_read_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] sz);
    case (sz)
      3'b001:  return {{24{w[7]}}, w[7:0]};
      3'b010:  return {{16{w[15]}}, w[15:0]};
      3'b101:  return {24'd0, w[7:0]};
      3'b110:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store(input logic [31:0] w, input logic [31:0] d, input logic [2:0] sz);
    case (sz)
      3'b001:  return {w[31:8], d[7:0]};
      3'b010:  return {w[31:16], d[15:0]};
      default: return d;
    endcase
  endfunction

  // Memory with a registered, size-extended read port; preloaded via ld_*.
  logic [31:0] mem [64];
  logic        ld_en;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_write) mem[mem_addr[5:0]] <= store(mem[mem_addr[5:0]], mem_write_data, mem_size);
    if (mem_read) mem_read_data <= ext(mem[mem_addr[5:0]], mem_size);
  end

  // Reference model: an accepted request at edge E grants after E, completes
  // after E+1, and the next request can only be taken at edge E+3.
  logic [31:0] ref_mem [64];
  int          ecount = 0;
  int          acc_edge = -10;
  int          free_edge = 0;
  bit          last_b = 1'b1;
  bit          m_sel_b, m_we, m_legal, m_in_rst;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_size;
  logic [31:0] e_addr = 0, e_wdata = 0;
  logic [2:0]  e_size = 0;

  always @(posedge clk) begin
    ecount++;
    m_in_rst = rst;
    if (ld_en) ref_mem[ld_addr] = ld_data;
    if (rst) begin
      acc_edge = -10; free_edge = 0; last_b = 1'b1;
      e_addr = 0; e_wdata = 0; e_size = 0;
    end else if (ecount >= free_edge && (a_req || b_req)) begin
      m_sel_b = b_req && (!a_req || !last_b);
      last_b  = m_sel_b;
      m_we    = m_sel_b ? b_we : a_we;
      m_addr  = m_sel_b ? b_addr : a_addr;
      m_wdata = m_sel_b ? b_wdata : a_wdata;
      m_size  = m_sel_b ? b_size : a_size;
      m_legal = (m_addr < 64) &&
                (m_we ? (m_size inside {3'd1, 3'd2, 3'd3})
                      : (m_size inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6}));
      m_rdata = 0;
      if (m_legal) begin
        e_addr = m_addr; e_wdata = m_wdata; e_size = m_size;
        if (m_we) ref_mem[m_addr[5:0]] = store(ref_mem[m_addr[5:0]], m_wdata, m_size);
        else m_rdata = ext(ref_mem[m_addr[5:0]], m_size);
      end
      acc_edge = ecount;
      free_edge = ecount + 3;
    end
  end

  bit checking = 1'b0;
  bit g_exp, d_exp;

  always @(negedge clk) begin
    if (checking) begin
      g_exp = (ecount == acc_edge);
      d_exp = (ecount == acc_edge + 1);
      check_eq("a_gnt", a_gnt, g_exp && !m_sel_b);
      check_eq("b_gnt", b_gnt, g_exp && m_sel_b);
      check_eq("mem_read", mem_read, g_exp && m_legal && !m_we);
      check_eq("mem_write", mem_write, g_exp && m_legal && m_we);
      check_eq("a_done", a_done, d_exp && !m_sel_b);
      check_eq("b_done", b_done, d_exp && m_sel_b);
      check_eq("err", err, d_exp && !m_legal);
      check_eq("mem_addr", mem_addr, e_addr);
      check_eq("mem_write_data", mem_write_data, e_wdata);
      check_eq("mem_size", mem_size, e_size);
      check_eq("gnt_excl", a_gnt & b_gnt, 0);
      check_eq("strobe_excl", mem_read & mem_write, 0);
      if (d_exp && !m_sel_b) check_eq("a_rdata", a_rdata, m_rdata);
      if (d_exp && m_sel_b)  check_eq("b_rdata", b_rdata, m_rdata);
      if (m_in_rst) begin
        check_eq("rst_a_rdata", a_rdata, 0);
        check_eq("rst_b_rdata", b_rdata, 0);
      end
      if (d_exp)
        $display("TXN t=%0t req=%s we=%0d addr=%0d size=%0d err=%0d rdata=%h",
                 $time, m_sel_b ? "B" : "A", m_we, m_addr, m_size, !m_legal, m_rdata);
    end
  end

  // One request from A (use_b=0) or B; waits a bounded time for its grant.
  task automatic issue(input bit use_b, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] size);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (use_b) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; b_size = size; end
    else       begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; a_size = size; end
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      got = use_b ? b_gnt : a_gnt;
    end
    if (!got) check_eq("gnt_timeout", 0, 1);
    a_req = 0; b_req = 0;
    repeat (2) @(posedge clk);
  endtask

  bit order [$];

  initial begin
    rst = 1; ld_en = 0; ld_addr = 0; ld_data = 0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_size = 3'b011;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_size = 3'b011;

    // Preload memory while held in reset.
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      checking = 1;
      ld_en = 1; ld_addr = 6'(i); ld_data = $urandom;
    end
    @(posedge clk); #1;
    ld_en = 0;

    // Reset held two cycles with A requesting: nothing may be granted.
    a_req = 1; a_we = 0; a_addr = 9; a_size = 3'b011;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    check_eq("rst_release_gnt", a_gnt, 1);
    check_eq("rst_release_read", mem_read, 1);
    a_req = 0;
    repeat (2) @(posedge clk);

    // Write then read back through requester A.
    issue(0, 1, 5, 32'hDEADBEEF, 3'b011);
    issue(0, 0, 5, 0, 3'b011);

    // Continuous contention right after reset alternates A, B, A, B.
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    a_req = 1; a_we = 0; a_addr = 1; a_size = 3'b011;
    b_req = 1; b_we = 0; b_addr = 2; b_size = 3'b011;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (a_gnt) order.push_back(1'b0);
      if (b_gnt) order.push_back(1'b1);
    end
    a_req = 0; b_req = 0;
    check_eq("contention_count", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      check_eq("contention_order", order[i], i % 2);
    repeat (3) @(posedge clk);

    // Illegal write size from B, and out-of-range read from A.
    issue(1, 1, 3, 32'h12345678, 3'b101);
    issue(0, 0, 64, 0, 3'b011);

    // Signed-byte read of 0x000000F0 returns the memory's extended value.
    issue(0, 1, 7, 32'h000000F0, 3'b011);
    issue(1, 0, 7, 0, 3'b001);

    // Reset during ISSUE abandons the access; a later one still completes.
    @(posedge clk); #1;
    a_req = 1; a_we = 0; a_addr = 5; a_size = 3'b011;
    @(posedge clk); #1;
    a_req = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    issue(0, 0, 5, 0, 3'b011);

    // Random traffic from both requesters with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(199) == 0);
      if (!(a_req && !a_gnt && $urandom_range(15) != 0)) begin
        a_req = $urandom_range(1); a_we = $urandom_range(1); a_wdata = $urandom;
        a_size = 3'($urandom_range(7));
        case ($urandom_range(9))
          0: a_addr = 64 + $urandom_range(7);
          1: a_addr = $urandom;
          default: a_addr = $urandom_range(63);
        endcase
      end
      if (!(b_req && !b_gnt && $urandom_range(15) != 0)) begin
        b_req = $urandom_range(1); b_we = $urandom_range(1); b_wdata = $urandom;
        b_size = 3'($urandom_range(7));
        case ($urandom_range(9))
          0: b_addr = 64 + $urandom_range(7);
          1: b_addr = $urandom;
          default: b_addr = $urandom_range(63);
        endcase
      end
    end
    rst = 0; a_req = 0; b_req = 0;
    repeat (5) @(posedge clk);
    #1 checking = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
